// File: rtl/reg_init_master.sv
// Register-initialisation sequencer: walks an (address, data) init table on start,
// writes each entry on the register bus and optionally reads it back for comparison.
module reg_init_master #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned VERIFY      = 1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [IDX_W-1:0]  tbl_idx,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic              reg_ack,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy,
    output logic              done,
    output logic              err_mismatch,
    output logic              err_timeout,
    output logic [IDX_W-1:0]  err_idx,
    output logic [IDX_W:0]    wr_count
);

    localparam int unsigned        CNT_W    = 16;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0]  END_MARK = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   tcnt, tcnt_n;
    logic [IDX_W-1:0]   idx_n, eidx_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [DATA_W-1:0]  wdata_n;
    logic [IDX_W:0]     wrc_n;
    logic               mis_n, to_n;
    logic               busy_n, done_n, req_n, we_n;
    logic               advance, xfer_wait, err_latched;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            tcnt         <= '0;
            tbl_idx      <= '0;
            reg_req      <= 1'b0;
            reg_we       <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
            err_idx      <= '0;
            wr_count     <= '0;
        end else begin
            state        <= state_n;
            tcnt         <= tcnt_n;
            tbl_idx      <= idx_n;
            reg_req      <= req_n;
            reg_we       <= we_n;
            reg_addr     <= addr_n;
            reg_wdata    <= wdata_n;
            busy         <= busy_n;
            done         <= done_n;
            err_mismatch <= mis_n;
            err_timeout  <= to_n;
            err_idx      <= eidx_n;
            wr_count     <= wrc_n;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        state_n     = state;
        tcnt_n      = tcnt;
        idx_n       = tbl_idx;
        addr_n      = reg_addr;
        wdata_n     = reg_wdata;
        mis_n       = err_mismatch;
        to_n        = err_timeout;
        eidx_n      = err_idx;
        wrc_n       = wr_count;
        advance     = 1'b0;
        xfer_wait   = 1'b0;
        err_latched = err_mismatch | err_timeout;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_FETCH;
                    idx_n   = '0;
                    mis_n   = 1'b0;
                    to_n    = 1'b0;
                    eidx_n  = '0;
                    wrc_n   = '0;
                end
            end
            S_FETCH: state_n = S_LOAD;
            S_LOAD: begin
                addr_n  = tbl_addr;
                wdata_n = tbl_data;
                tcnt_n  = '0;
                state_n = (tbl_addr == END_MARK) ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                if (reg_ack) begin
                    wrc_n = wr_count + 1'b1;
                    if (VERIFY != 0) begin
                        state_n = S_READ;
                        tcnt_n  = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    xfer_wait = 1'b1;
                end
            end
            S_READ: begin
                if (reg_ack) begin
                    if (reg_rdata != reg_wdata) begin
                        mis_n = 1'b1;
                        if (!err_latched) eidx_n = tbl_idx;
                    end
                    advance = 1'b1;
                end else begin
                    xfer_wait = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // An ack in the limit cycle is handled above, so only a missing ack gets here.
        if (xfer_wait) begin
            if (tcnt == TO_LAST) begin
                to_n    = 1'b1;
                state_n = S_DONE;
                if (!err_latched) eidx_n = tbl_idx;
            end else begin
                tcnt_n = tcnt + 1'b1;
            end
        end

        if (advance) begin
            if (tbl_idx == LAST_IDX) begin
                state_n = S_DONE;
            end else begin
                idx_n   = tbl_idx + 1'b1;
                state_n = S_FETCH;
            end
        end

        busy_n = (state_n == S_FETCH) || (state_n == S_LOAD) ||
                 (state_n == S_WRITE) || (state_n == S_READ);
        req_n  = (state_n == S_WRITE) || (state_n == S_READ);
        we_n   = (state_n == S_WRITE);
        done_n = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_reg_init_master.sv
// Bench for reg_init_master: table ROM and register responder models, directed and
// randomized sequences checked against an entry-by-entry reference of the sequence rules.
module tb_reg_init_master;

    localparam int unsigned ADDR_W      = 12;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned NUM_ENTRIES = 4;
    localparam int unsigned VERIFY      = 1;
    localparam int unsigned TIMEOUT     = 8;
    localparam int unsigned BUDGET      = 300;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [IDX_W-1:0]  tbl_idx;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_data;
    logic              reg_req, reg_we, reg_ack;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata, reg_rdata;
    logic              busy, done, err_mismatch, err_timeout;
    logic [IDX_W-1:0]  err_idx;
    logic [IDX_W:0]    wr_count;

    reg_init_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W),
        .NUM_ENTRIES(NUM_ENTRIES), .VERIFY(VERIFY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata),
        .busy(busy), .done(done), .err_mismatch(err_mismatch), .err_timeout(err_timeout),
        .err_idx(err_idx), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Init table ROM with one cycle of read latency
    logic [ADDR_W-1:0] tab_a [16];
    logic [DATA_W-1:0] tab_d [16];
    always @(posedge clk) begin
        tbl_addr <= tab_a[tbl_idx];
        tbl_data <= tab_d[tbl_idx];
    end

    // Register responder: random wait states, optional hang or corrupted readback
    logic [DATA_W-1:0] mem [1 << ADDR_W];
    int unsigned       wcnt = 0, wait_n = 0, max_wait = 0;
    bit                hang_en = 0, corr_en = 0;
    logic [IDX_W-1:0]  hang_i = '0, corr_i = '0;
    txn_t              log_q [$];

    assign reg_ack   = reg_req && !(hang_en && reg_addr == tab_a[hang_i]) && (wcnt >= wait_n);
    assign reg_rdata = (corr_en && reg_addr == tab_a[corr_i]) ? '0 : mem[reg_addr];

    always @(posedge clk) begin
        if (reg_req && reg_ack) begin
            if (reg_we) mem[reg_addr] <= reg_wdata;
            log_q.push_back({reg_we, reg_addr, reg_we ? reg_wdata : reg_rdata});
        end
        if (!reg_req || reg_ack) begin
            wcnt   <= 0;
            wait_n <= $urandom_range(max_wait);
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what the sequence must do, entry by entry
    txn_t exp_q [$];
    int   exp_wr, exp_eidx, exp_cyc;
    bit   exp_mis, exp_to;

    task automatic run_model();
        logic [DATA_W-1:0] rd;
        exp_q.delete();
        exp_wr = 0; exp_mis = 0; exp_to = 0; exp_eidx = 0; exp_cyc = 1;
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            exp_cyc += 2;
            if (tab_a[i] == 12'hfff) break;
            if (hang_en && int'(hang_i) == i) begin
                exp_to = 1;
                if (!exp_mis) exp_eidx = i;
                break;
            end
            exp_q.push_back({1'b1, tab_a[i], tab_d[i]});
            exp_wr++;
            exp_cyc++;
            if (VERIFY != 0) begin
                rd = (corr_en && int'(corr_i) == i) ? '0 : tab_d[i];
                exp_q.push_back({1'b0, tab_a[i], rd});
                exp_cyc++;
                if (rd != tab_d[i] && !exp_mis) begin
                    exp_mis  = 1;
                    exp_eidx = i;
                end
            end
        end
    endtask

    task automatic set_fixed();
        for (int i = 0; i < 16; i++) begin
            tab_a[i] = 12'h400 + 12'(i * 4);
            tab_d[i] = 32'h0;
        end
        tab_a[0] = 12'h120; tab_d[0] = 32'h0a0b0c0d;
        tab_a[1] = 12'h124; tab_d[1] = 32'h1a1b1c1d;
        tab_a[2] = 12'h128; tab_d[2] = 32'h2a2b2c2d;
        tab_a[3] = 12'h12c; tab_d[3] = 32'h01020304;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic start_seq();
        log_q.delete();
        run_model();
        pulse_start();
    endtask

    task automatic wait_done(input int cyc0, output int cyc, output int hi, output bit ok);
        cyc = cyc0; hi = 0; ok = 0;
        while (cyc <= int'(BUDGET)) begin
            if (reg_req && hang_en && reg_addr == tab_a[hang_i]) hi++;
            if (done) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic finish_seq(input string name, input int cyc0);
        int cyc, hi, n;
        bit ok;
        wait_done(cyc0, cyc, hi, ok);
        check({name, " done_within_budget"}, ok, 1);
        check({name, " done"}, done, 1);
        check({name, " busy"}, busy, 0);
        check({name, " reg_req"}, reg_req, 0);
        check({name, " wr_count"}, wr_count, exp_wr);
        check({name, " err_mismatch"}, err_mismatch, exp_mis);
        check({name, " err_timeout"}, err_timeout, exp_to);
        check({name, " err_idx"}, err_idx, exp_eidx);
        if (hang_en) check({name, " req_high_cycles"}, hi, exp_to ? TIMEOUT : 0);
        check({name, " txn_count"}, log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s txn%0d", name, i), log_q[i], exp_q[i]);
        if (max_wait == 0 && !hang_en) check({name, " done_cycle"}, cyc, exp_cyc);
    endtask

    task automatic check_zero(input string name);
        check({name, " busy"}, busy, 0);
        check({name, " done"}, done, 0);
        check({name, " reg_req"}, reg_req, 0);
        check({name, " reg_we"}, reg_we, 0);
        check({name, " reg_addr"}, reg_addr, 0);
        check({name, " reg_wdata"}, reg_wdata, 0);
        check({name, " tbl_idx"}, tbl_idx, 0);
        check({name, " err_flags"}, {err_mismatch, err_timeout}, 0);
        check({name, " err_idx"}, err_idx, 0);
        check({name, " wr_count"}, wr_count, 0);
    endtask

    initial begin
        int k;
        logic [ADDR_W-1:0] base;
        set_fixed();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_zero("reset");

        // Zero-wait full table with cycle-accurate first transaction
        start_seq();
        check("t1 busy_c1", busy, 1);
        check("t1 req_c1", reg_req, 0);
        @(posedge clk); #1;
        check("t1 req_c2", reg_req, 0);
        @(posedge clk); #1;
        check("t1 req_c3", reg_req, 1);
        check("t1 we_c3", reg_we, 1);
        check("t1 addr_c3", reg_addr, 12'h120);
        check("t1 wdata_c3", reg_wdata, 32'h0a0b0c0d);
        finish_seq("t1", 3);
        check("t1 done_at_17", exp_cyc, 17);

        // Corrupted readback of entry 2
        corr_en = 1; corr_i = 4'd2;
        start_seq();
        finish_seq("t2", 1);
        check("t2 err_idx_is_2", err_idx, 2);

        // Restart from DONE clears flags; start while busy is ignored
        corr_en = 0;
        start_seq();
        check("t6 done_cleared", done, 0);
        check("t6 mis_cleared", err_mismatch, 0);
        check("t6 wrc_cleared", wr_count, 0);
        check("t6 busy", busy, 1);
        @(posedge clk); #1;
        pulse_start();
        finish_seq("t6", 3);

        // Entry 1 never acknowledged
        hang_en = 1; hang_i = 4'd1;
        start_seq();
        finish_seq("t3", 1);

        // End marker at entry 2
        hang_en = 0;
        tab_a[2] = 12'hfff;
        start_seq();
        finish_seq("t4", 1);
        set_fixed();

        // Reset during the stalled write of entry 1, then a clean rerun
        hang_en = 1; hang_i = 4'd1;
        start_seq();
        k = 0;
        while (k < 50 && !(reg_req && reg_we && reg_addr == tab_a[1])) begin
            @(posedge clk); #1;
            k++;
        end
        check("t5 reached_write1", k < 50, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("t5 reset");
        reset = 1'b0;
        hang_en = 0;
        @(posedge clk); #1;
        start_seq();
        finish_seq("t5 rerun", 1);

        // Randomized tables, wait states and fault placement
        for (int it = 0; it < 10; it++) begin
            base = 12'($urandom_range(12'h700));
            for (int i = 0; i < 16; i++) begin
                tab_a[i] = base + 12'(i * 4);
                tab_d[i] = $urandom | 32'h1;
            end
            max_wait = $urandom_range(3);
            hang_en  = ($urandom_range(3) == 0);
            hang_i   = 4'($urandom_range(NUM_ENTRIES - 1));
            corr_en  = ($urandom_range(2) == 0);
            corr_i   = 4'($urandom_range(NUM_ENTRIES - 1));
            if ($urandom_range(3) == 0) tab_a[$urandom_range(NUM_ENTRIES - 1)] = 12'hfff;
            @(posedge clk); #1;
            start_seq();
            finish_seq($sformatf("rnd%0d", it), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
